// File: rtl/kernel_conv.sv
// kernel_conv: streaming K x K convolution window with normalising divide.
// A kernel (coefficients, divisor, edge length K) is loaded, then K*K window
// pixels are multiply-accumulated in raster order. The sum is divided by the
// kernel divisor with a 32-step restoring divider, saturated to the pixel
// range, and presented on a valid/ready output.
// Build option: define KCONV_ROUND_EN for round-half-up; otherwise truncate.
module kernel_conv #(
  parameter int MAX_KERNEL = 7,
  parameter int PIX_W      = 8,
  localparam int KS_W      = $clog2(MAX_KERNEL)
) (
  input  logic                                            clk,
  input  logic                                            n_rst,
  input  logic                                            kernel_load,
  output logic                                            kernel_ready,
  input  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][PIX_W-1:0] kernel_in,
  input  logic [31:0]                                     kernel_sum,
  input  logic [KS_W-1:0]                                 kernel_size,
  input  logic                                            pix_valid,
  output logic                                            pix_ready,
  input  logic [PIX_W-1:0]                                pix_in,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [PIX_W-1:0]                                out_pixel,
  output logic                                            err_zero
);

  typedef enum logic [1:0] {EMPTY, ACCUM, DIV, OUT} state_e;

  localparam logic [PIX_W-1:0] PIX_MAX = '1;

  state_e                                           state_q, state_d;
  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][PIX_W-1:0] coef_q, coef_d;
  logic [31:0]                                      sum_q, sum_d;
  logic [KS_W-1:0]                                  size_q, size_d;
  logic [KS_W-1:0]                                  x_q, x_d;
  logic [KS_W-1:0]                                  y_q, y_d;
  logic [31:0]                                      acc_q, acc_d;
  logic [31:0]                                      rem_q, rem_d;
  logic [31:0]                                      quo_q, quo_d;
  logic [4:0]                                       iter_q, iter_d;
  logic [PIX_W-1:0]                                 out_pix_q, out_pix_d;
  logic                                             err_q, err_d;
  logic                                             live_q;

  logic                   load_acc;
  logic                   load_bad;
  logic                   pix_fire;
  logic [PIX_W-1:0]       coef_cur;
  logic [2*PIX_W-1:0]     prod;
  logic [31:0]            acc_sum;
  logic [31:0]            round_term;
  logic [KS_W-1:0]        k_last;
  logic                   x_end;
  logic                   win_last;
  logic [32:0]            rem_shift;
  logic [32:0]            rem_diff;
  logic                   rem_ge;
  logic [31:0]            rem_next;
  logic [31:0]            quo_next;
  logic [PIX_W-1:0]       quo_sat;

`ifdef KCONV_ROUND_EN
  assign round_term = sum_q >> 1;
`else
  assign round_term = '0;
`endif

  // Handshake qualifiers. live_q holds kernel_ready low until the first edge
  // after reset release, even though the state is already EMPTY.
  assign kernel_ready = live_q &&
                        ((state_q == EMPTY) ||
                         ((state_q == ACCUM) && (x_q == '0) && (y_q == '0)));
  assign load_acc     = kernel_load && kernel_ready;
  assign load_bad     = (kernel_sum == '0) || (kernel_size == '0);
  // A coincident accepted load takes priority over the first window pixel.
  assign pix_ready    = (state_q == ACCUM) && !load_acc;
  assign pix_fire     = pix_valid && pix_ready;

  // Window datapath: only positions inside K x K are ever addressed.
  assign coef_cur = coef_q[y_q][x_q];
  assign prod     = pix_in * coef_cur;
  assign acc_sum  = acc_q + 32'(prod);
  assign k_last   = size_q - KS_W'(1);
  assign x_end    = (x_q == k_last);
  assign win_last = x_end && (y_q == k_last);

  // One restoring-divide step. The remainder always stays below the divisor,
  // so a non-negative difference never reaches bit 32 and bit 32 of the
  // difference is exactly the borrow.
  assign rem_shift = {rem_q, quo_q[31]};
  assign rem_diff  = rem_shift - {1'b0, sum_q};
  assign rem_ge    = ~rem_diff[32];
  assign rem_next  = rem_ge ? rem_diff[31:0] : rem_shift[31:0];
  assign quo_next  = {quo_q[30:0], rem_ge};
  assign quo_sat   = (|quo_next[31:PIX_W]) ? PIX_MAX : quo_next[PIX_W-1:0];

  // Next-state, kernel capture, accumulate and divide control.
  always_comb begin
    // NOTE: every _d takes its hold value first so no branch can infer a latch.
    state_d   = state_q;
    coef_d    = coef_q;
    sum_d     = sum_q;
    size_d    = size_q;
    x_d       = x_q;
    y_d       = y_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    iter_d    = iter_q;
    out_pix_d = out_pix_q;
    err_d     = err_q;

    if (load_acc) begin
      if (load_bad) begin
        // Rejected kernel: flag it and drop whatever was presented.
        err_d   = 1'b1;
        state_d = EMPTY;
        coef_d  = '0;
        sum_d   = '0;
        size_d  = '0;
      end else begin
        coef_d  = kernel_in;
        sum_d   = kernel_sum;
        size_d  = kernel_size;
        err_d   = 1'b0;
        state_d = ACCUM;
        acc_d   = '0;
        x_d     = '0;
        y_d     = '0;
      end
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (pix_fire) begin
            acc_d = acc_sum;
            if (win_last) begin
              state_d = DIV;
              x_d     = '0;
              y_d     = '0;
              rem_d   = '0;
              quo_d   = acc_sum + round_term;
              iter_d  = '0;
            end else if (x_end) begin
              x_d = '0;
              y_d = y_q + KS_W'(1);
            end else begin
              x_d = x_q + KS_W'(1);
            end
          end
        end
        DIV: begin
          rem_d  = rem_next;
          quo_d  = quo_next;
          iter_d = iter_q + 5'd1;
          if (iter_q == 5'd31) begin
            state_d   = OUT;
            out_pix_d = quo_sat;
          end
        end
        OUT: begin
          if (out_ready) begin
            state_d = ACCUM;
            acc_d   = '0;
            x_d     = '0;
            y_d     = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // State register; reset abandons any window or divide in flight.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= EMPTY;
      // NOTE: kernel storage is reset too, so nothing from a previous run can
      // leak into a result after reset.
      coef_q    <= '0;
      sum_q     <= '0;
      size_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      iter_q    <= '0;
      out_pix_q <= '0;
      err_q     <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      coef_q    <= coef_d;
      sum_q     <= sum_d;
      size_q    <= size_d;
      x_q       <= x_d;
      y_q       <= y_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      iter_q    <= iter_d;
      out_pix_q <= out_pix_d;
      err_q     <= err_d;
      live_q    <= 1'b1;
    end
  end

  assign out_valid = (state_q == OUT);
  assign out_pixel = out_pix_q;
  assign err_zero  = err_q;

endmodule
